// File: rtl/enemy_tank_ai_if.sv
// ---------------------------------------------------------------------------
// enemy_tank_ai_if
//   Bundles the timing strobes, tank status and tank command signals that run
//   between the game logic and one enemy_tank_ai instance.
//
//   Signals
//     move_tick_i   1-cycle strobe, one per tank movement step
//     sec_tick_i    1-cycle strobe, one per second
//     blocked_i     tank is against a wall in its current direction (level)
//     tank_die_i    tank killed (level, cleared externally on revive)
//     tank_move_o   one-hot move command (0001 dn, 0010 up, 0100 rt, 1000 lt), 0 = still
//     tank_shoot_o  shoot request
//     tank_revive_o 1-cycle revive pulse
//     ai_state_o    FSM state: 0 IDLE, 1 MOVE, 2 TURN, 3 DEAD
//
//   Modports
//     master : game side, drives strobes/status, receives commands
//     slave  : AI side, receives strobes/status, drives commands
// ---------------------------------------------------------------------------
interface enemy_tank_ai_if;
    logic       move_tick_i;
    logic       sec_tick_i;
    logic       blocked_i;
    logic       tank_die_i;
    logic [3:0] tank_move_o;
    logic       tank_shoot_o;
    logic       tank_revive_o;
    logic [1:0] ai_state_o;

    modport master (
        output move_tick_i, sec_tick_i, blocked_i, tank_die_i,
        input  tank_move_o, tank_shoot_o, tank_revive_o, ai_state_o
    );

    modport slave (
        input  move_tick_i, sec_tick_i, blocked_i, tank_die_i,
        output tank_move_o, tank_shoot_o, tank_revive_o, ai_state_o
    );
endinterface

// File: rtl/enemy_tank_ai.sv
// ---------------------------------------------------------------------------
// enemy_tank_ai
//   Autonomous command source for one enemy tank. Wanders in pseudo-random
//   straight runs, turns when blocked or when a run ends, fires on a cooldown
//   and issues a revive pulse a fixed number of seconds after being killed.
//
//   Ports
//     clk_i    system clock
//     reset_i  asynchronous reset, active-high
//     bus      enemy_tank_ai_if.slave: strobes/status in, tank commands out
//
//   All outputs are registered from next-state values, so a state change is
//   visible on the outputs one cycle after the input that caused it.
// ---------------------------------------------------------------------------
module enemy_tank_ai #(
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter logic [3:0]  DIR_INIT       = 4'b0001,
    parameter logic [7:0]  MIN_RUN        = 8'd16,
    parameter logic [7:0]  START_DELAY    = 8'd2,
    parameter logic [7:0]  SHOOT_COOLDOWN = 8'd3,
    parameter logic [3:0]  SHOOT_HOLD     = 4'd4,
    parameter logic [7:0]  RESPAWN_SECS   = 8'd5
) (
    input  logic            clk_i,
    input  logic            reset_i,
    enemy_tank_ai_if.slave  bus
);

    // An all-zero Galois LFSR would lock up, so a zero seed becomes 1.
    localparam logic [15:0] LFSR_INIT = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_TURN = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    state_t      r_state,        w_state_next;
    logic [3:0]  r_dir,          w_dir_next;
    logic [15:0] r_lfsr,         w_lfsr_next;
    logic [7:0]  r_sec_cnt,      w_sec_cnt_next;
    logic [7:0]  r_step_cnt,     w_step_cnt_next;
    logic [7:0]  r_run_len,      w_run_len_next;
    logic [7:0]  r_cooldown,     w_cooldown_next;
    logic [3:0]  r_shot_cnt,     w_shot_cnt_next;
    logic        r_turn_blocked, w_turn_blocked_next;
    logic [3:0]  r_move;
    logic        r_shoot;
    logic        r_revive;
    logic        w_revive_next;

    logic [7:0]  w_sec_inc;
    logic [7:0]  w_step_inc;
    logic [7:0]  w_run_rand;
    logic [3:0]  w_dir_rand;
    logic        w_fire;

    always_comb begin
        w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
        w_run_rand  = MIN_RUN + {2'b00, r_lfsr[5:0]};
        w_dir_rand  = 4'b0001 << r_lfsr[1:0];
        w_sec_inc   = r_sec_cnt + {7'd0, bus.sec_tick_i};
        w_step_inc  = r_step_cnt + {7'd0, bus.move_tick_i};
        // A kill in the same cycle suppresses a new shot.
        w_fire      = (r_state == ST_MOVE) && !bus.tank_die_i &&
                      (r_cooldown == '0) && (r_shot_cnt == '0);
    end

    // Next-state / datapath for the wander FSM.
    always_comb begin
        w_state_next        = r_state;
        w_dir_next          = r_dir;
        w_sec_cnt_next      = r_sec_cnt;
        w_step_cnt_next     = r_step_cnt;
        w_run_len_next      = r_run_len;
        w_turn_blocked_next = r_turn_blocked;
        w_revive_next       = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.tank_die_i) begin
                    w_state_next   = ST_DEAD;
                    w_sec_cnt_next = '0;
                end else if (w_sec_inc == START_DELAY) begin
                    w_state_next    = ST_MOVE;
                    w_sec_cnt_next  = '0;
                    w_run_len_next  = w_run_rand;
                    w_step_cnt_next = '0;
                end else begin
                    w_sec_cnt_next = w_sec_inc;
                end
            end
            ST_MOVE: begin
                if (bus.tank_die_i) begin
                    w_state_next   = ST_DEAD;
                    w_sec_cnt_next = '0;
                end else if (bus.blocked_i) begin
                    w_state_next        = ST_TURN;
                    w_turn_blocked_next = 1'b1;
                end else if (w_step_inc == r_run_len) begin
                    w_state_next        = ST_TURN;
                    w_turn_blocked_next = 1'b0;
                end else begin
                    w_step_cnt_next = w_step_inc;
                end
            end
            ST_TURN: begin
                if (bus.tank_die_i) begin
                    w_state_next   = ST_DEAD;
                    w_sec_cnt_next = '0;
                end else begin
                    // A wall-forced turn must not pick the blocked heading again.
                    if (r_turn_blocked && (w_dir_rand == r_dir)) begin
                        w_dir_next = {r_dir[2:0], r_dir[3]};
                    end else begin
                        w_dir_next = w_dir_rand;
                    end
                    w_run_len_next  = w_run_rand;
                    w_step_cnt_next = '0;
                    w_state_next    = ST_MOVE;
                end
            end
            ST_DEAD: begin
                if (w_sec_inc == RESPAWN_SECS) begin
                    w_state_next   = ST_IDLE;
                    w_sec_cnt_next = '0;
                    w_dir_next     = DIR_INIT;
                    w_revive_next  = 1'b1;
                end else begin
                    w_sec_cnt_next = w_sec_inc;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Cooldown and shot-hold counters run beside the FSM.
    always_comb begin
        w_cooldown_next = r_cooldown;
        w_shot_cnt_next = r_shot_cnt;

        if (r_state == ST_DEAD) begin
            if (w_revive_next) begin
                w_cooldown_next = SHOOT_COOLDOWN;
            end
        end else if (w_fire) begin
            w_cooldown_next = SHOOT_COOLDOWN;
        end else if (bus.sec_tick_i && (r_cooldown != '0)) begin
            w_cooldown_next = r_cooldown - 8'd1;
        end

        if ((r_state == ST_DEAD) || bus.tank_die_i) begin
            w_shot_cnt_next = '0;
        end else if (w_fire) begin
            w_shot_cnt_next = SHOOT_HOLD;
        end else if (r_shot_cnt != '0) begin
            w_shot_cnt_next = r_shot_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state        <= ST_IDLE;
            r_dir          <= DIR_INIT;
            r_lfsr         <= LFSR_INIT;
            r_sec_cnt      <= '0;
            r_step_cnt     <= '0;
            r_run_len      <= '0;
            r_cooldown     <= SHOOT_COOLDOWN;
            r_shot_cnt     <= '0;
            r_turn_blocked <= 1'b0;
            r_move         <= '0;
            r_shoot        <= 1'b0;
            r_revive       <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_dir          <= w_dir_next;
            r_lfsr         <= w_lfsr_next;
            r_sec_cnt      <= w_sec_cnt_next;
            r_step_cnt     <= w_step_cnt_next;
            r_run_len      <= w_run_len_next;
            r_cooldown     <= w_cooldown_next;
            r_shot_cnt     <= w_shot_cnt_next;
            r_turn_blocked <= w_turn_blocked_next;
            r_move         <= (w_state_next == ST_MOVE) ? w_dir_next : 4'b0000;
            r_shoot        <= (w_shot_cnt_next != '0);
            r_revive       <= w_revive_next;
        end
    end

    assign bus.tank_move_o   = r_move;
    assign bus.tank_shoot_o  = r_shoot;
    assign bus.tank_revive_o = r_revive;
    assign bus.ai_state_o    = r_state;

endmodule

// File: tb/tb_enemy_tank_ai.sv
// ---------------------------------------------------------------------------
// tb_enemy_tank_ai
//   Self-checking bench for enemy_tank_ai. A cycle model predicts the outputs
//   at every rising edge and queues them; a monitor on the falling edge pops
//   each prediction and compares it with the DUT. Directed sequences cover
//   reset mid-run, wall-forced turn rotation, shot width/spacing, death
//   mid-shot and death/blocked coincidence.
// ---------------------------------------------------------------------------
module tb_enemy_tank_ai;

    localparam logic [15:0] SEED     = 16'hACE1;
    localparam logic [3:0]  INIT_DIR = 4'b0001;
    localparam logic [7:0]  MIN_RUN  = 8'd16;
    localparam logic [7:0]  START    = 8'd2;
    localparam logic [7:0]  COOL     = 8'd3;
    localparam logic [3:0]  HOLD     = 4'd4;
    localparam logic [7:0]  RESP     = 8'd5;
    localparam int          SEC_PER  = 16;

    logic clk_i = 1'b0;
    logic reset_i;

    enemy_tank_ai_if tif();

    enemy_tank_ai #(
        .LFSR_SEED     (SEED),
        .DIR_INIT      (INIT_DIR),
        .MIN_RUN       (MIN_RUN),
        .START_DELAY   (START),
        .SHOOT_COOLDOWN(COOL),
        .SHOOT_HOLD    (HOLD),
        .RESPAWN_SECS  (RESP)
    ) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .bus    (tif)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [3:0] move;
        logic       shoot;
        logic       revive;
        logic [1:0] state;
    } exp_t;

    exp_t sb_q[$];

    int          m_state, m_sec, m_step, m_run, m_cool, m_shot;
    logic [3:0]  m_dir;
    logic [15:0] m_lfsr;
    bit          m_tblk;

    task automatic model_reset();
        m_state = 0; m_sec = 0; m_step = 0; m_run = 0;
        m_cool  = int'(COOL); m_shot = 0; m_tblk = 0;
        m_dir   = INIT_DIR;
        m_lfsr  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    endtask

    task automatic model_step();
        logic [15:0] l;
        logic [3:0]  nd;
        bit          mt, st, blk, die, fire, rev;
        exp_t        e;
        l   = m_lfsr;
        mt  = tif.move_tick_i;
        st  = tif.sec_tick_i;
        blk = tif.blocked_i;
        die = tif.tank_die_i;
        m_lfsr = lfsr_adv(l);
        rev  = 0;
        fire = (m_state == 1) && !die && (m_cool == 0) && (m_shot == 0);
        if (m_state != 3) begin
            if (die)             m_shot = 0;
            else if (fire)       m_shot = int'(HOLD);
            else if (m_shot > 0) m_shot--;
            if (fire)                   m_cool = int'(COOL);
            else if (st && m_cool > 0)  m_cool--;
        end
        if (m_state != 3 && die) begin
            m_state = 3;
            m_sec   = 0;
        end else begin
            case (m_state)
                0: begin
                    m_sec += int'(st);
                    if (m_sec == int'(START)) begin
                        m_state = 1; m_sec = 0; m_step = 0;
                        m_run = int'(MIN_RUN) + int'(l[5:0]);
                    end
                end
                1: begin
                    m_step += int'(mt);
                    if (blk) begin
                        m_state = 2; m_tblk = 1;
                    end else if (m_step == m_run) begin
                        m_state = 2; m_tblk = 0;
                    end
                end
                2: begin
                    nd = 4'b0001 << l[1:0];
                    if (m_tblk && nd == m_dir) nd = {m_dir[2:0], m_dir[3]};
                    m_dir = nd;
                    m_run = int'(MIN_RUN) + int'(l[5:0]);
                    m_step = 0;
                    m_state = 1;
                end
                default: begin
                    m_sec += int'(st);
                    if (m_sec == int'(RESP)) begin
                        rev = 1; m_dir = INIT_DIR; m_cool = int'(COOL);
                        m_state = 0; m_sec = 0;
                    end
                end
            endcase
        end
        e.move   = (m_state == 1) ? m_dir : 4'b0000;
        e.shoot  = (m_shot != 0);
        e.revive = rev;
        e.state  = 2'(m_state);
        sb_q.push_back(e);
    endtask

    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            exp_t e;
            model_reset();
            sb_q.delete();
            e = '0;
            sb_q.push_back(e);
        end else begin
            model_step();
        end
    end

    bit mon_en = 0;

    always @(negedge clk_i) begin
        if (mon_en && sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq("sb_move",   tif.tank_move_o,   e.move);
            check_eq("sb_shoot",  tif.tank_shoot_o,  e.shoot);
            check_eq("sb_revive", tif.tank_revive_o, e.revive);
            check_eq("sb_state",  tif.ai_state_o,    e.state);
        end
    end

    // ---------------- stimulus ----------------
    int cyc      = 0;
    bit move_all = 0;
    bit last_sec = 0;

    // Applies one cycle of inputs; entered and left at posedge+2.
    task automatic step(input logic blk, input logic die);
        tif.sec_tick_i  = ((cyc % SEC_PER) == SEC_PER - 1);
        tif.move_tick_i = move_all ? 1'b1 : 1'($urandom_range(0, 1));
        tif.blocked_i   = blk;
        tif.tank_die_i  = die;
        last_sec        = tif.sec_tick_i;
        @(posedge clk_i);
        #2;
        cyc++;
    endtask

    task automatic wait_dut_state(input int s, input int budget, input string tag);
        int k = 0;
        while (tif.ai_state_o != 2'(s) && k < budget) begin
            step(1'b0, 1'b0);
            k++;
        end
        check_eq(tag, tif.ai_state_o, s);
    endtask

    // Holds tank_die_i high until the revive pulse, counting DEAD-state seconds.
    task automatic hold_dead(input string tag);
        int         ticks = 0;
        int         k = 0;
        logic [1:0] pre;
        while (tif.tank_revive_o !== 1'b1 && k < 400) begin
            pre = tif.ai_state_o;
            step(1'b0, 1'b1);
            if (pre == 2'd3 && last_sec) ticks++;
            k++;
        end
        check_eq({tag, "_revive"}, tif.tank_revive_o, 1);
        check_eq({tag, "_ticks"},  ticks, RESP);
        check_eq({tag, "_idle"},   tif.ai_state_o, 0);
        step(1'b0, 1'b0);
        check_eq({tag, "_pulse1"}, tif.tank_revive_o, 0);
    endtask

    initial begin
        int          w, ticks, k;
        bit          found;
        logic [15:0] nl;

        reset_i         = 1'b1;
        tif.move_tick_i = 1'b0;
        tif.sec_tick_i  = 1'b0;
        tif.blocked_i   = 1'b0;
        tif.tank_die_i  = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        reset_i = 1'b0;
        mon_en  = 1;
        check_eq("rst_move",   tif.tank_move_o,   0);
        check_eq("rst_shoot",  tif.tank_shoot_o,  0);
        check_eq("rst_revive", tif.tank_revive_o, 0);
        check_eq("rst_state",  tif.ai_state_o,    0);

        // T1: reset in the middle of a run
        wait_dut_state(1, 200, "t1_reach_move");
        repeat (10) step(1'b0, 1'b0);
        reset_i = 1'b1;
        #1;
        check_eq("t1_move",   tif.tank_move_o,   0);
        check_eq("t1_shoot",  tif.tank_shoot_o,  0);
        check_eq("t1_revive", tif.tank_revive_o, 0);
        check_eq("t1_state",  tif.ai_state_o,    0);
        step(1'b0, 1'b0);
        reset_i = 1'b0;
        wait_dut_state(1, 200, "t1_restart");
        check_eq("t1_dir_init", tif.tank_move_o, INIT_DIR);

        // T4: shot width and spacing
        k = 0;
        while (tif.tank_shoot_o !== 1'b1 && k < 400) begin step(1'b0, 1'b0); k++; end
        check_eq("t4_first_shot", tif.tank_shoot_o, 1);
        w = 0; ticks = 0;
        while (tif.tank_shoot_o === 1'b1 && w < 20) begin
            step(1'b0, 1'b0);
            w++;
            if (last_sec) ticks++;
        end
        check_eq("t4_width", w, HOLD);
        k = 0;
        while (tif.tank_shoot_o !== 1'b1 && k < 400) begin
            step(1'b0, 1'b0);
            k++;
            if (last_sec) ticks++;
        end
        check_eq("t4_second_shot", tif.tank_shoot_o, 1);
        check_eq("t4_gap_ge_cool", (ticks >= int'(COOL)), 1);

        // T5: killed mid-shot
        step(1'b0, 1'b1);
        check_eq("t5_shoot_drop", tif.tank_shoot_o, 0);
        check_eq("t5_dead",       tif.ai_state_o,   3);
        hold_dead("t5");

        // T6: death and wall in the same cycle
        wait_dut_state(1, 200, "t6_reach_move");
        step(1'b1, 1'b1);
        check_eq("t6_dead", tif.ai_state_o, 3);
        check_eq("t6_move", tif.tank_move_o, 0);
        hold_dead("t6");

        // T3: blocked heading right while the TURN draw also says right
        move_all = 1;
        found = 0;
        k = 0;
        while (!found && k < 20000) begin
            nl = lfsr_adv(m_lfsr);
            if (m_state == 1 && m_dir == 4'b0100 && nl[1:0] == 2'd2) found = 1;
            else begin step(1'b0, 1'b0); k++; end
        end
        check_eq("t3_found", found, 1);
        step(1'b1, 1'b0);
        check_eq("t3_turn_state", tif.ai_state_o, 2);
        check_eq("t3_turn_move",  tif.tank_move_o, 0);
        step(1'b0, 1'b0);
        check_eq("t3_rotated", tif.tank_move_o, 4'b1000);

        // Free-running mix of walls and occasional kills
        move_all = 0;
        repeat (1500) step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 299) == 0));
        step(1'b0, 1'b0);
        mon_en = 0;
        repeat (2) @(posedge clk_i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
